timekeeper: RTL and testbench
=============================

// Module: timekeeper
// PURPOSE
//  Time-of-day source for the DE10-lite clock display. Produces h/m/s and the
//  half-second dot consumed by the 6-digit 7-segment display driver. Derives a
//  1 Hz tick from the board clock and lets the user set hours and minutes from
//  two push-buttons. Sits between the board clock/KEY pins and the display.
// PARAMETERS
//  CLK_HZ           50_000_000  input clock frequency; prescaler modulus
//  DEBOUNCE_CYCLES  1_000_000   stable cycles required before a key edge counts
// PORTS
//  clk       in   1  board clock (MAX10_CLK1_50)
//  rst       in   1  synchronous reset, active-high
//  key_h_n   in   1  raw KEY, active-low, asynchronous: press = hour +1
//  key_m_n   in   1  raw KEY, active-low, asynchronous: press = minute +1
//  hold      in   1  1 = freeze time (prescaler and s stop); set keys still work
//  h         out  5  hours 0..23
//  m         out  6  minutes 0..59
//  s         out  6  seconds 0..59
//  dot       out  1  segment-level dot, active-low: 0 = lit
//  tick_1hz  out  1  one-cycle pulse on every seconds increment
// BEHAVIOUR
//  Reset: h=0, m=0, s=0, dot=1, tick_1hz=0, prescaler=0, pending=0, debouncers idle.
//   Reset applies mid-operation on the next edge and overrides all events.
//  Prescaler: counts 0..CLK_HZ-1 when hold=0 and wraps to 0.
//   tick_1hz=1 for exactly the cycle after the prescaler is CLK_HZ-1.
//   s increments on that same edge.
//  Rollover: s 59->0 carries to m. m 59->0 carries to h. h 23->0 with no carry.
//   All outputs are registered and update on the same edge as tick_1hz.
//  Dot: registered. dot=0 while prescaler < CLK_HZ/2, else 1.
//   dot=1 whenever hold=1.
//  Keys: each raw key goes through a 2-flop synchroniser, then the debouncer.
//   The debounced level is accepted after DEBOUNCE_CYCLES consecutive equal
//   samples. A press pulse (1 cycle) fires on the accepted 1->0 transition.
//   Release produces no action. Holding a key does not auto-repeat.
//  Set, hour key: h = (h+1) mod 24. m, s and prescaler are untouched.
//  Set, minute key: m = (m+1) mod 60, s=0, prescaler=0, with no carry into h.
//  Collisions: a press pulse arriving on a tick edge is latched in pending_h or
//   pending_m and applied on the next non-tick cycle. A pulse is never lost and
//   never applied twice. Both key pulses in one cycle apply together.
//  hold=1 with a tick in flight: no tick is issued, and the prescaler keeps its
//   value. Counting resumes from that value when hold returns to 0.
//  Widths: counters use unsigned compare to the MAX constants; never rely on
//   natural binary wrap of the 5/6-bit fields.
// STRUCTURE
//  Package clock_pkg: H_MAX=23, M_MAX=59, S_MAX=59; typedefs hour_t (5b),
//   min_t (6b), sec_t (6b). These are shared with the display driver.
//  Sub-module key_debounce (#DEBOUNCE_CYCLES): clk, rst, key_n -> press.
//   It contains the synchroniser, stability counter and edge detector.
//   It is instantiated twice.
//  Top level holds the prescaler, dot register, h/m/s counters and pending flags.
// TESTING  (CLK_HZ=10, DEBOUNCE_CYCLES=4)
//  1. Reset, then run 10 cycles -> one tick_1hz pulse, s=1.
//     dot=0 for prescaler 0..4, dot=1 for 5..9.
//  2. Preload 23:59:58, run 20 cycles -> 23:59:59, then 00:00:00 on the second
//     tick, each with a single tick_1hz pulse.
//  3. key_h_n low with 3-cycle glitches, then stable low for 10 cycles ->
//     exactly one h increment. 23 -> 0 with m and s unchanged.
//     Release -> no change.
//  4. Minute press at 10:59:30 -> 10:00:00 with h unchanged.
//     Prescaler restarts, so the next tick arrives 10 cycles later.
//  5. Time the hour press pulse onto the tick edge at 05:59:59.
//     -> 06:00:00 on the tick, then 07:00:00 one cycle later.
//  6. hold=1 for 25 cycles mid-second -> no tick, s constant, dot=1.
//     Assert rst during hold -> all reset values next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the clock datapath and the
// 7-segment display driver.
//   H_MAX/M_MAX/S_MAX : last legal value of each field (inclusive)
//   hour_t/min_t/sec_t: field types (5/6/6 bits)
//   *_inc             : modulo increment that compares to the MAX constant
//                       instead of relying on binary wrap of the field
package clock_pkg;

  localparam int unsigned H_MAX = 23;
  localparam int unsigned M_MAX = 59;
  localparam int unsigned S_MAX = 59;

  typedef logic [4:0] hour_t;
  typedef logic [5:0] min_t;
  typedef logic [5:0] sec_t;

  function automatic hour_t hour_inc(input hour_t v);
    return (v >= hour_t'(H_MAX)) ? '0 : v + 1'b1;
  endfunction

  function automatic min_t min_inc(input min_t v);
    return (v >= min_t'(M_MAX)) ? '0 : v + 1'b1;
  endfunction

  function automatic sec_t sec_inc(input sec_t v);
    return (v >= sec_t'(S_MAX)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// falling-edge detector for one active-low raw KEY pin.
//   clk   : board clock
//   rst   : synchronous reset, active-high (button treated as released)
//   key_n : raw asynchronous key level, active-low
//   press : one-cycle pulse when a press (1->0) is accepted
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// samples that differ from the currently accepted level; any sample equal to
// the accepted level restarts the count. Releases are accepted silently.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
          press  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/timekeeper.sv
// Time-of-day source for the DE10-lite clock display.
//   clk      : board clock (MAX10_CLK1_50)
//   rst      : synchronous reset, active-high
//   key_h_n  : raw active-low KEY, press = hour +1
//   key_m_n  : raw active-low KEY, press = minute +1 (clears s and prescaler)
//   hold     : freeze prescaler and seconds; set keys keep working
//   h/m/s    : registered time of day
//   dot      : active-low half-second dot (0 = lit), forced dark under hold
//   tick_1hz : one-cycle pulse on every seconds increment
module timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  key_h_n,
  input  logic  key_m_n,
  input  logic  hold,
  output hour_t h,
  output min_t  m,
  output sec_t  s,
  output logic  dot,
  output logic  tick_1hz
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF    = PW'(CLK_HZ / 2);

  logic          press_h;
  logic          press_m;
  logic          pend_h;
  logic          pend_m;
  logic          want_h;
  logic          want_m;
  logic          tick_now;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_h (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_h_n),
    .press (press_h)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_m (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_m_n),
    .press (press_m)
  );

  // A set request is either a fresh pulse or one parked by a tick edge;
  // it is applied only on a non-tick edge, so the two never meet in h/m/s.
  always_comb begin
    tick_now = ~hold && (pre == PRE_MAX);
    want_h   = press_h | pend_h;
    want_m   = press_m | pend_m;
    pre_nxt  = pre;
    if (tick_now) begin
      pre_nxt = '0;
    end else if (want_m) begin
      pre_nxt = '0;
    end else if (!hold) begin
      pre_nxt = pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h        <= '0;
      m        <= '0;
      s        <= '0;
      pre      <= '0;
      dot      <= 1'b1;
      tick_1hz <= 1'b0;
      pend_h   <= 1'b0;
      pend_m   <= 1'b0;
    end else begin
      pre      <= pre_nxt;
      tick_1hz <= tick_now;
      // Computed from the next prescaler value so dot lines up with pre.
      dot      <= hold | (pre_nxt >= HALF);
      pend_h   <= tick_now & want_h;
      pend_m   <= tick_now & want_m;
      if (tick_now) begin
        s <= sec_inc(s);
        if (s >= sec_t'(S_MAX)) begin
          m <= min_inc(m);
          if (m >= min_t'(M_MAX)) begin
            h <= hour_inc(h);
          end
        end
      end else begin
        if (want_h) begin
          h <= hour_inc(h);
        end
        if (want_m) begin
          m <= min_inc(m);
          s <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_timekeeper.sv
// Self-checking bench for timekeeper (CLK_HZ=10, DEBOUNCE_CYCLES=4):
// directed scenarios with literal expectations, then randomized keys/hold/rst,
// all compared every cycle against a behavioural time-of-day model.
module tb_timekeeper;
  import clock_pkg::*;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;
  localparam int HW     = DB + 2;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  key_h_n = 1'b1;
  logic  key_m_n = 1'b1;
  logic  hold = 1'b0;
  hour_t h;
  min_t  m;
  sec_t  s;
  logic  dot;
  logic  tick_1hz;

  timekeeper #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_h_n  (key_h_n),
    .key_m_n  (key_m_n),
    .hold     (hold),
    .h        (h),
    .m        (m),
    .s        (s),
    .dot      (dot),
    .tick_1hz (tick_1hz)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int eh, em, es, epre, edot, etick;
  int par_h, par_m;          // set requests parked by a tick edge
  int prs[2];                // debounced press pulse visible this cycle
  int acc[2];                // accepted key level
  int hist[2][HW];           // raw key samples, [0] = newest
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    int tk, hp, mp, samp, same;
    int raw[2];
    if (rst) begin
      eh = 0; em = 0; es = 0; epre = 0; edot = 1; etick = 0;
      par_h = 0; par_m = 0;
      for (int k = 0; k < 2; k++) begin
        prs[k] = 0;
        acc[k] = 1;
        for (int i = 0; i < HW; i++) hist[k][i] = 1;
      end
      model_ok = 1'b1;
    end else begin
      tk = (hold == 1'b0 && epre == CLK_HZ - 1) ? 1 : 0;
      hp = (prs[0] != 0 || par_h != 0) ? 1 : 0;
      mp = (prs[1] != 0 || par_m != 0) ? 1 : 0;
      if (tk != 0) begin
        epre = 0;
        es = (es + 1) % 60;
        if (es == 0) begin
          em = (em + 1) % 60;
          if (em == 0) eh = (eh + 1) % 24;
        end
        par_h = hp;
        par_m = mp;
      end else begin
        if (hp != 0) eh = (eh + 1) % 24;
        if (mp != 0) begin
          em = (em + 1) % 60;
          es = 0;
          epre = 0;
        end else if (hold == 1'b0) begin
          epre = epre + 1;
        end
        par_h = 0;
        par_m = 0;
      end
      etick = tk;
      edot  = (hold == 1'b1 || epre >= CLK_HZ / 2) ? 1 : 0;
      // Key path: the debouncer sees the raw level from two edges back and
      // accepts it once the last DB such samples all agree on a new level.
      raw[0] = int'(key_h_n);
      raw[1] = int'(key_m_n);
      for (int k = 0; k < 2; k++) begin
        for (int i = HW - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = raw[k];
        samp = hist[k][2];
        same = 1;
        for (int i = 2; i < HW; i++) if (hist[k][i] != samp) same = 0;
        prs[k] = 0;
        if (same != 0 && samp != acc[k]) begin
          acc[k] = samp;
          prs[k] = (samp == 0) ? 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("h",    int'(h),        eh);
      chk("m",    int'(m),        em);
      chk("s",    int'(s),        es);
      chk("dot",  int'(dot),      edot);
      chk("tick", int'(tick_1hz), etick);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_key(input int which);
    if (which == 0) key_h_n = 1'b0; else key_m_n = 1'b0;
    step(DB + 4);
    if (which == 0) key_h_n = 1'b1; else key_m_n = 1'b1;
    step(DB + 4);
  endtask

  // Sets hours then minutes with the keys, time frozen by hold.
  task automatic set_hm(input int th, input int tm);
    int n;
    hold = 1'b1;
    n = 0;
    while (eh != th && n < 30) begin press_key(0); n++; end
    chk("set_h_bound", eh, th);
    n = 0;
    while (em != tm && n < 70) begin press_key(1); n++; end
    chk("set_m_bound", em, tm);
    hold = 1'b0;
  endtask

  // Waits until the tick that makes seconds equal ts.
  task automatic wait_tick_to(input int ts);
    int n;
    n = 0;
    while (!(etick == 1 && es == ts) && n < 800) begin step(1); n++; end
    chk("wait_tick_bound", (n < 800) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, sv_m, sv_s, n;
    int cd[2];

    // 1. reset, first second, dot phase
    step(2);
    chk("rst_h", int'(h), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_dot", int'(dot), 1);
    chk("rst_tick", int'(tick_1hz), 0);
    rst = 1'b0;
    step(4);
    chk("dot_pre4", int'(dot), 0);
    step(1);
    chk("dot_pre5", int'(dot), 1);
    step(5);
    chk("first_tick", int'(tick_1hz), 1);
    chk("first_s", int'(s), 1);

    // 2. rollover 23:59:58 -> 23:59:59 -> 00:00:00
    set_hm(23, 59);
    wait_tick_to(58);
    chk("pre_58_h", int'(h), 23);
    chk("pre_58_m", int'(m), 59);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin step(1); ticks += int'(tick_1hz); end
    chk("t2_s59", int'(s), 59);
    for (int i = 0; i < 10; i++) begin step(1); ticks += int'(tick_1hz); end
    chk("t2_ticks", ticks, 2);
    chk("t2_h0", int'(h), 0);
    chk("t2_m0", int'(m), 0);
    chk("t2_s0", int'(s), 0);

    // 3. glitchy hour key at 23 under hold
    set_hm(23, em);
    hold = 1'b1;
    step(2);
    sv_m = em;
    sv_s = es;
    for (int g = 0; g < 3; g++) begin
      key_h_n = 1'b0; step(3);
      key_h_n = 1'b1; step(3);
    end
    chk("glitch_no_inc", int'(h), 23);
    key_h_n = 1'b0;
    step(10);
    chk("t3_h", int'(h), 0);
    chk("t3_m", int'(m), sv_m);
    chk("t3_s", int'(s), sv_s);
    key_h_n = 1'b1;
    step(10);
    chk("t3_release_h", int'(h), 0);
    hold = 1'b0;

    // 4. minute press at 10:59:30
    set_hm(10, 59);
    wait_tick_to(30);
    key_m_n = 1'b0;
    n = 0;
    while (em != 0 && n < 20) begin step(1); n++; end
    chk("t4_h", int'(h), 10);
    chk("t4_m", int'(m), 0);
    chk("t4_s", int'(s), 0);
    n = 0;
    do begin step(1); n++; end while (tick_1hz != 1'b1 && n < 30);
    chk("t4_tick_gap", n, 10);
    key_m_n = 1'b1;
    step(DB + 4);

    // 5. hour pulse lands on the tick edge at 05:59:59
    set_hm(5, 59);
    wait_tick_to(59);
    step(3);
    key_h_n = 1'b0;
    step(7);
    chk("t5_tick", int'(tick_1hz), 1);
    chk("t5_h6", int'(h), 6);
    chk("t5_m0", int'(m), 0);
    chk("t5_s0", int'(s), 0);
    step(1);
    chk("t5_h7", int'(h), 7);
    key_h_n = 1'b1;
    step(DB + 4);
    chk("t5_h7_after", int'(h), 7);

    // 6. hold mid-second, then reset during hold
    step(3);
    hold = 1'b1;
    sv_s = es;
    ticks = 0;
    for (int i = 0; i < 25; i++) begin step(1); ticks += int'(tick_1hz); end
    chk("t6_ticks", ticks, 0);
    chk("t6_s", int'(s), sv_s);
    chk("t6_dot", int'(dot), 1);
    rst = 1'b1;
    step(1);
    chk("t6_rst_h", int'(h), 0);
    chk("t6_rst_m", int'(m), 0);
    chk("t6_rst_s", int'(s), 0);
    chk("t6_rst_dot", int'(dot), 1);
    chk("t6_rst_tick", int'(tick_1hz), 0);
    rst = 1'b0;
    hold = 1'b0;

    // randomized keys/hold/reset against the model
    cd[0] = 0;
    cd[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) hold = ~hold;
      rst = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (cd[k] == 0) begin
          cd[k] = int'($urandom_range(1, 12));
          if (k == 0) key_h_n = 1'($urandom_range(0, 1));
          else        key_m_n = 1'($urandom_range(0, 1));
        end else begin
          cd[k]--;
        end
      end
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
